// File: rtl/audio_echo_stage.sv
`default_nettype none
// ============================================================================
// Module      : audio_echo_stage
// Description : Stereo echo stage. Each input pair is mixed with a delayed,
//               attenuated tap from a circular buffer and saturated.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_echo_stage #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int DECAY_SHIFT = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ADDR_W-1:0]        delay_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_L,
    input  logic signed [DATA_W-1:0] in_R,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_L,
    output logic signed [DATA_W-1:0] out_R
);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_MIX   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]               r_state;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_clr_cnt;
    logic [ADDR_W-1:0]        r_delay;
    logic                     r_en;
    logic signed [DATA_W-1:0] r_in_l;
    logic signed [DATA_W-1:0] r_in_r;
    logic signed [DATA_W-1:0] r_rd_l;
    logic signed [DATA_W-1:0] r_rd_r;
    logic [DATA_W-1:0]        r_mem_l [DEPTH];
    logic [DATA_W-1:0]        r_mem_r [DEPTH];

    logic                     w_we;
    logic [ADDR_W-1:0]        w_wr_addr;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [DATA_W-1:0]        w_wr_l;
    logic [DATA_W-1:0]        w_wr_r;
    logic signed [DATA_W-1:0] w_mix_l;
    logic signed [DATA_W-1:0] w_mix_r;

    function automatic logic signed [DATA_W-1:0] mix_sat(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] d,
        input logic                     en
    );
        logic signed [DATA_W-1:0] tap;
        logic signed [DATA_W:0]   sum;
        tap = d >>> DECAY_SHIFT;
        sum = {x[DATA_W-1], x} + {tap[DATA_W-1], tap};
        if (!en)
            mix_sat = x;
        else if (sum[DATA_W] != sum[DATA_W-1])
            mix_sat = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
        else
            mix_sat = sum[DATA_W-1:0];
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    // Modulo-DEPTH subtraction makes a delay of 0 read the slot about to be overwritten.
    assign w_rd_addr = r_wr_ptr - r_delay;
    assign w_we      = (r_state == S_CLEAR) || (r_state == S_MIX);
    assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_cnt : r_wr_ptr;
    assign w_wr_l    = (r_state == S_CLEAR) ? '0 : r_in_l;
    assign w_wr_r    = (r_state == S_CLEAR) ? '0 : r_in_r;
    assign w_mix_l   = mix_sat(r_in_l, r_rd_l, r_en);
    assign w_mix_r   = mix_sat(r_in_r, r_rd_r, r_en);

    // Delay RAM: reads happen only in RD, writes only in CLEAR/MIX.
    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem_l[w_wr_addr] <= w_wr_l;
            r_mem_r[w_wr_addr] <= w_wr_r;
        end
        if (r_state == S_RD) begin
            r_rd_l <= r_mem_l[w_rd_addr];
            r_rd_r <= r_mem_r[w_rd_addr];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_wr_ptr  <= '0;
            r_delay   <= '0;
            r_en      <= 1'b0;
            r_in_l    <= '0;
            r_in_r    <= '0;
            out_valid <= 1'b0;
            out_L     <= '0;
            out_R     <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1))
                        r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_l  <= in_L;
                        r_in_r  <= in_R;
                        r_delay <= delay_len;
                        r_en    <= enable;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_MIX;
                end
                S_MIX: begin
                    out_L     <= w_mix_l;
                    out_R     <= w_mix_r;
                    out_valid <= 1'b1;
                    r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_echo_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_echo_stage
// Description : Self-checking bench for audio_echo_stage with DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_echo_stage;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
        logic        en;
        logic [3:0]  dly;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  delay_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_L;
    logic [31:0] in_R;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_L;
    logic [31:0] out_R;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    audio_echo_stage #(
        .DATA_W      (32),
        .DEPTH       (16),
        .DECAY_SHIFT (1)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .enable    (enable),
        .delay_len (delay_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_L      (in_L),
        .in_R      (in_R),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_L     (out_L),
        .out_R     (out_R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] l, input logic [31:0] r, input logic en,
                       input logic [3:0] dly, input logic [31:0] el, input logic [31:0] er);
        vec_t v;
        v.l = l; v.r = r; v.en = en; v.dly = dly; v.el = el; v.er = er;
        tbl.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic start_xfer(input vec_t v, output bit ok);
        int cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        ok = in_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_wait: in_ready=0 required=1 after %0d cycles", cnt);
            return;
        end
        in_L = v.l; in_R = v.r; enable = v.en; delay_len = v.dly; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        in_valid  = 1'b0;
        enable    = ~v.en;
        delay_len = v.dly + 4'd3;
    endtask

    task automatic do_xfer(input vec_t v, input int hold, input string name);
        bit   ok;
        int   cnt;
        vec_t e;
        start_xfer(v, ok);
        if (!ok) return;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, "_latency"}, cnt, 2);
        if (!out_valid) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk({name, "_L"}, out_L, e.el);
        chk({name, "_R"}, out_R, e.er);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_L = 32'hDEAD_BEEF;
            in_R = 32'h1234_5678;
            @(negedge clk);
            chk({name, "_hold_vr"}, {30'd0, out_valid, in_ready}, 32'd2);
            chk({name, "_hold_LR"}, {31'd0, (out_L !== e.el) || (out_R !== e.er)}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit   ok;
        int   cnt;
        vec_t v;

        reset = 1'b1; enable = 1'b0; delay_len = '0; in_valid = 1'b0;
        in_L = '0; in_R = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out", {29'd0, out_valid, |out_L, |out_R}, 32'd0);

        // Clear pass after release: ready only after 16 edges.
        reset = 1'b0;
        chk("clear_ready_0", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("clear_ready_%0d", k), {31'd0, in_ready}, 32'(k == 16));
            chk("clear_out", {29'd0, out_valid, |out_L, |out_R}, 32'd0);
        end

        // Impulse, pointers 0..5
        add(32'd1000, -32'sd1000, 1'b1, 4'd4, 32'd1000, -32'sd1000);
        repeat (3) add(32'd0, 32'd0, 1'b1, 4'd4, 32'd0, 32'd0);
        add(32'd0, 32'd0, 1'b1, 4'd4, 32'd500, -32'sd500);
        add(32'd0, 32'd0, 1'b1, 4'd4, 32'd0, 32'd0);
        // Bypass, pointers 6..10, then echo with delay 5 at pointer 11
        add(32'd1000, -32'sd1000, 1'b0, 4'd4, 32'd1000, -32'sd1000);
        repeat (4) add(32'd0, 32'd0, 1'b0, 4'd4, 32'd0, 32'd0);
        add(32'd0, 32'd0, 1'b1, 4'd5, 32'd500, -32'sd500);
        // Saturation, pointers 12..15 and wrap to 0
        add(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000);
        add(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000);
        add(32'd0, 32'd0, 1'b1, 4'd1, 32'h3FFF_FFFF, 32'hC000_0000);
        add(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF);
        add(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd1, 32'h8000_0000, 32'h7FFF_FFFF);
        // delay_len=0 means DEPTH, pointers 1..6; pointer 6 still holds the bypassed impulse
        repeat (5) add(32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0);
        add(32'd7, -32'sd7, 1'b1, 4'd0, 32'd507, -32'sd507);

        foreach (tbl[i]) do_xfer(tbl[i], 0, $sformatf("vec%0d", i));

        // Backpressure at pointer 7; follow-up at pointer 8 shows only one transfer happened.
        v = '{l: 32'd123, r: -32'sd456, en: 1'b1, dly: 4'd3, el: 32'd123, er: -32'sd456};
        do_xfer(v, 10, "bp");
        v = '{l: 32'd0, r: 32'd0, en: 1'b1, dly: 4'd1, el: 32'd61, er: -32'sd228};
        do_xfer(v, 0, "bp_next");

        // Reset while holding output in OUT
        v = '{l: 32'd55, r: 32'd66, en: 1'b1, dly: 4'd1, el: 32'd55, er: 32'd66};
        start_xfer(v, ok);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rstout_pre_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstout_valid", {31'd0, out_valid}, 32'd0);
        chk("rstout_L", out_L, 32'd0);
        chk("rstout_R", out_R, 32'd0);
        chk("rstout_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        v = '{l: 32'd100, r: -32'sd100, en: 1'b1, dly: 4'd1, el: 32'd100, er: -32'sd100};
        do_xfer(v, 0, "post_rst1");

        // Reset while the sample sits in MIX
        v = '{l: 32'd77, r: 32'd88, en: 1'b1, dly: 4'd2, el: 32'd77, er: 32'd88};
        start_xfer(v, ok);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmix_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmix_L", out_L, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        // Pointer 0 held 100 before the second clear; it must read back as zero.
        v = '{l: 32'd5, r: -32'sd5, en: 1'b1, dly: 4'd0, el: 32'd5, er: -32'sd5};
        do_xfer(v, 0, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
